// File: rtl/demux_1to2_buffered.sv
// demux_1to2_buffered
//   Splits one valid/ready word stream into two independently drained queues.
//   Each accepted word is steered by in_sel (0 = A, 1 = B) to the tail of its
//   queue; order is preserved within each destination.
//
// Ports
//   Clk                      clock, all state changes on the rising edge
//   Reset                    synchronous active-low reset
//   in_valid/in_data/in_sel  producer word, with its destination select
//   in_ready                 selected queue is not full (the word is taken)
//   outA_valid/data/ready    queue A head and consumer handshake
//   outB_valid/data/ready    queue B head and consumer handshake
//   cntA/cntB                words accepted per destination, wrapping
module demux_1to2_buffered #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2,
  parameter int CNT_W = 8
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_sel,
  output logic             in_ready,
  output logic             outA_valid,
  output logic [WIDTH-1:0] outA_data,
  input  logic             outA_ready,
  output logic             outB_valid,
  output logic [WIDTH-1:0] outB_data,
  input  logic             outB_ready,
  output logic [CNT_W-1:0] cntA,
  output logic [CNT_W-1:0] cntB
);

  localparam int PW = $clog2(DEPTH);
  localparam int OW = PW + 1;
  localparam logic [OW-1:0] OCC_FULL = OW'(DEPTH);

  // Index 0 is queue A, index 1 is queue B.
  logic [WIDTH-1:0] mem    [2][DEPTH];
  logic [PW-1:0]    wr_ptr [2];
  logic [PW-1:0]    rd_ptr [2];
  logic [OW-1:0]    occ    [2];
  logic [WIDTH-1:0] head   [2];
  logic [CNT_W-1:0] cnt    [2];

  logic [1:0] full;
  logic [1:0] push;
  logic [1:0] pop;
  logic [1:0] out_ready;

  assign out_ready = {outB_ready, outA_ready};

  // Acceptance depends only on registered occupancy, so a full queue refuses
  // a push even when its consumer pops on the same edge.
  always_comb begin
    full = '0;
    push = '0;
    pop  = '0;
    for (int q = 0; q < 2; q++) begin
      full[q] = (occ[q] == OCC_FULL);
      pop[q]  = (occ[q] != '0) && out_ready[q];
    end
    push[0] = in_valid && !in_sel && !full[0];
    push[1] = in_valid &&  in_sel && !full[1];
  end

  assign in_ready = in_sel ? !full[1] : !full[0];

  // head[] is a registered copy of the queue head so the output data holds
  // its last value once the queue runs empty.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      for (int q = 0; q < 2; q++) begin
        wr_ptr[q] <= '0;
        rd_ptr[q] <= '0;
        occ[q]    <= '0;
        head[q]   <= '0;
        cnt[q]    <= '0;
      end
    end else begin
      for (int q = 0; q < 2; q++) begin
        if (push[q]) begin
          mem[q][wr_ptr[q]] <= in_data;
          wr_ptr[q]         <= wr_ptr[q] + PW'(1);
          cnt[q]            <= cnt[q] + CNT_W'(1);
        end
        if (pop[q]) begin
          rd_ptr[q] <= rd_ptr[q] + PW'(1);
        end
        case ({push[q], pop[q]})
          2'b10:   occ[q] <= occ[q] + OW'(1);
          2'b01:   occ[q] <= occ[q] - OW'(1);
          default: occ[q] <= occ[q];
        endcase
        if (pop[q]) begin
          // Next head is the second stored entry, or the word arriving now
          // when the queue held only the entry being popped.
          if (occ[q] > OW'(1)) begin
            head[q] <= mem[q][rd_ptr[q] + PW'(1)];
          end else if (push[q]) begin
            head[q] <= in_data;
          end
        end else if (push[q] && (occ[q] == '0)) begin
          head[q] <= in_data;
        end
      end
    end
  end

  assign outA_valid = (occ[0] != '0);
  assign outB_valid = (occ[1] != '0);
  assign outA_data  = head[0];
  assign outB_data  = head[1];
  assign cntA       = cnt[0];
  assign cntB       = cnt[1];

endmodule

// File: tb/tb_demux_1to2_buffered.sv
module tb_demux_1to2_buffered;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        in_valid;
  logic [31:0] in_data;
  logic        in_sel;
  logic        in_ready;
  logic        outA_valid;
  logic [31:0] outA_data;
  logic        outA_ready;
  logic        outB_valid;
  logic [31:0] outB_data;
  logic        outB_ready;
  logic [7:0]  cntA;
  logic [7:0]  cntB;

  int tests = 0;
  int fails = 0;
  int delA  = 0;
  int delB  = 0;

  logic [31:0] expA[$];
  logic [31:0] expB[$];

  demux_1to2_buffered #(.WIDTH(32), .DEPTH(2), .CNT_W(8)) dut (
    .Clk(Clk), .Reset(Reset),
    .in_valid(in_valid), .in_data(in_data), .in_sel(in_sel), .in_ready(in_ready),
    .outA_valid(outA_valid), .outA_data(outA_data), .outA_ready(outA_ready),
    .outB_valid(outB_valid), .outB_data(outB_data), .outB_ready(outB_ready),
    .cntA(cntA), .cntB(cntB)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard: accepted words are queued, delivered words are popped and compared.
  always @(negedge Clk) begin
    if (!Reset) begin
      expA.delete();
      expB.delete();
    end else begin
      if (outA_valid && outA_ready) begin
        if (expA.size() == 0) begin
          tests++; fails++;
          $display("FAIL scbA_unexpected: got 0x%0h, expected no word", outA_data);
        end else begin
          check("scbA_data", outA_data, expA.pop_front());
        end
        delA++;
      end
      if (outB_valid && outB_ready) begin
        if (expB.size() == 0) begin
          tests++; fails++;
          $display("FAIL scbB_unexpected: got 0x%0h, expected no word", outB_data);
        end else begin
          check("scbB_data", outB_data, expB.pop_front());
        end
        delB++;
      end
      if (in_valid && in_ready) begin
        if (in_sel) expB.push_back(in_data);
        else        expA.push_back(in_data);
      end
    end
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // Offer one word until accepted (bounded); returns the number of stalled cycles.
  task automatic push(input logic [31:0] d, input logic s, output int waited);
    in_valid = 1'b1;
    in_data  = d;
    in_sel   = s;
    waited   = 0;
    forever begin
      @(negedge Clk);
      if (in_ready) break;
      waited++;
      if (waited > 20) begin
        tests++; fails++;
        $display("FAIL push_timeout: got stalled %0d cycles, expected acceptance", waited);
        break;
      end
    end
    @(posedge Clk);
    #1;
    in_valid = 1'b0;
  endtask

  initial begin
    int w;
    int da, db;
    Reset = 1'b0; in_valid = 1'b1; in_sel = 1'b0; in_data = 32'hDEAD_BEEF;
    outA_ready = 1'b1; outB_ready = 1'b1;

    // Reset held with in_valid asserted
    for (int i = 0; i < 2; i++) begin
      tick();
      @(negedge Clk);
      check("rst_validA", outA_valid, 0);
      check("rst_validB", outB_valid, 0);
      check("rst_cntA", cntA, 0);
      check("rst_cntB", cntB, 0);
      check("rst_dataA", outA_data, 0);
    end
    @(posedge Clk); #1;
    Reset = 1'b1; in_valid = 1'b0;
    tick();
    @(negedge Clk);
    check("rel_validA", outA_valid, 0);
    check("rel_validB", outB_valid, 0);
    check("rel_cntA", cntA, 0);
    @(posedge Clk); #1;

    // Basic steering and one-cycle latency
    push(32'hA000_0001, 1'b0, w);
    @(negedge Clk);
    check("lat_validA", outA_valid, 1);
    check("lat_dataA", outA_data, 32'hA000_0001);
    @(posedge Clk); #1;
    push(32'hB000_0002, 1'b1, w);
    @(negedge Clk);
    check("lat_validB", outB_valid, 1);
    check("lat_dataB", outB_data, 32'hB000_0002);
    @(posedge Clk); #1;
    @(negedge Clk);
    check("basic_cntA", cntA, 1);
    check("basic_cntB", cntB, 1);
    check("basic_drainA", outA_valid, 0);
    @(posedge Clk); #1;

    // Fill A with consumer stalled; third word must stall
    outA_ready = 1'b0;
    push(32'h11, 1'b0, w);
    push(32'h22, 1'b0, w);
    in_valid = 1'b1; in_sel = 1'b0; in_data = 32'h33;
    for (int i = 0; i < 3; i++) begin
      @(negedge Clk);
      check("full_in_ready", in_ready, 0);
      check("full_headA", outA_data, 32'h11);
      @(posedge Clk); #1;
    end
    in_valid = 1'b0;

    // B flows while A is full and stalled
    push(32'hB1, 1'b1, w); check("B_nostall1", w, 0);
    push(32'hB2, 1'b1, w); check("B_nostall2", w, 0);
    @(negedge Clk);
    check("A_held_data", outA_data, 32'h11);
    check("A_held_valid", outA_valid, 1);
    check("A_cnt_held", cntA, 3);
    @(posedge Clk); #1;

    // Release A; 0x33 goes in once a slot frees
    outA_ready = 1'b1;
    push(32'h33, 1'b0, w);
    check("refill_stall", w, 1);
    repeat (4) tick();
    check("drainA_empty", outA_valid, 0);
    check("drainA_hold", outA_data, 32'h33);

    // Reset, then steady push+pop at occupancy 1
    Reset = 1'b0; tick(); Reset = 1'b1;
    outA_ready = 1'b0;
    in_valid = 1'b1; in_sel = 1'b0; in_data = 32'd0;
    tick();
    outA_ready = 1'b1;
    for (int i = 1; i < 10; i++) begin
      in_data = i;
      @(negedge Clk);
      check("pp_in_ready", in_ready, 1);
      check("pp_validA", outA_valid, 1);
      check("pp_dataA", outA_data, i - 1);
      @(posedge Clk); #1;
    end
    in_valid = 1'b0;
    @(negedge Clk);
    check("pp_last", outA_data, 9);
    @(posedge Clk); #1;
    @(negedge Clk);
    check("pp_empty", outA_valid, 0);
    check("pp_cntA", cntA, 10);
    @(posedge Clk); #1;

    // Reset with both queues full
    outA_ready = 1'b0; outB_ready = 1'b0;
    push(32'h61, 1'b0, w); push(32'h62, 1'b0, w);
    push(32'h71, 1'b1, w); push(32'h72, 1'b1, w);
    @(negedge Clk);
    check("bothfull_validB", outB_valid, 1);
    @(posedge Clk); #1;
    Reset = 1'b0; outA_ready = 1'b1; outB_ready = 1'b1;
    in_valid = 1'b1; in_sel = 1'b0; in_data = 32'h99;
    tick();
    @(negedge Clk);
    check("midrst_validA", outA_valid, 0);
    check("midrst_validB", outB_valid, 0);
    check("midrst_cntA", cntA, 0);
    check("midrst_cntB", cntB, 0);
    @(posedge Clk); #1;
    Reset = 1'b1;
    da = delA; db = delB;
    push(32'h00C0_FFEE, 1'b1, w);
    repeat (4) tick();
    check("postrst_delB", delB - db, 1);
    check("postrst_delA", delA - da, 0);
    check("postrst_cntB", cntB, 1);

    // Counter wrap on B
    Reset = 1'b0; tick(); Reset = 1'b1;
    db = delB;
    for (int i = 0; i < 256; i++) begin
      push(32'h1000 + i, 1'b1, w);
      if (i == 254) check("wrap_cnt255", cntB, 255);
    end
    check("wrap_cnt0", cntB, 0);
    repeat (4) tick();
    check("wrap_delivered", delB - db, 256);

    check("end_scbA_empty", expA.size(), 0);
    check("end_scbB_empty", expB.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got no finish, expected finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/demux_1to2_buffered.md
Name: demux_1to2_buffered

Overview:
- One-to-two demultiplexer: the splitting counterpart of the datapath 2:1 select muxes.
- Takes one valid/ready word stream. Each accepted word is steered by a per-word select bit into one of two destination queues, A or B.
- Each destination drains independently through its own valid/ready port. Order is preserved within each destination.
- Used where one producer (e.g. write-back or memory-return path) feeds two consumers that may stall independently.

Parameters:
- WIDTH, 32, data word width in bits.
- DEPTH, 2, entries per destination queue (power of two, at least 2).
- CNT_W, 8, width of the per-destination accepted-word counters.

Ports:
- Clk  input  1  clock; all state changes on the rising edge.
- Reset  input  1  synchronous, active-low reset (0 = reset, sampled on the rising edge of Clk).
- in_valid  input  1  input word present.
- in_data  input  WIDTH  input word.
- in_sel  input  1  destination select: 0 = A, 1 = B.
- in_ready  output  1  the word offered this cycle is accepted.
- outA_valid  output  1  queue A non-empty.
- outA_data  output  WIDTH  head of queue A.
- outA_ready  input  1  consumer A takes the head.
- outB_valid  output  1  queue B non-empty.
- outB_data  output  WIDTH  head of queue B.
- outB_ready  input  1  consumer B takes the head.
- cntA  output  CNT_W  words accepted into A since reset, wraps modulo 2^CNT_W.
- cntB  output  CNT_W  words accepted into B since reset, wraps modulo 2^CNT_W.

Behaviour:
- Reset (Reset == 0 at a rising edge):
  - Both queues are emptied; read/write pointers and occupancy are cleared.
  - Outputs next cycle: outA_valid = 0, outB_valid = 0, cntA = 0, cntB = 0, outA_data = 0, outB_data = 0.
  - Reset mid-transfer discards all queued words, and no handshake completes on that edge.
- in_ready = !full of the queue selected by in_sel.
  - Purely a function of in_sel and registered occupancy; there is no combinational path from outA_ready or outB_ready.
  - A full queue refuses a push even if it pops in the same cycle.
- Accept: in_valid && in_ready at a rising edge. in_data is written to the tail of the selected queue, and that queue's counter increments.
- Offering to a full queue stalls the input. Nothing is dropped, the other queue is unaffected, and in_ready stays 0 until the selected queue frees a slot.
- Latency:
  - A word accepted at edge N into an empty queue shows valid and data immediately after edge N, i.e. it is visible in cycle N+1.
  - No bypass within the same cycle.
- Pop: outX_valid && outX_ready at an edge advances that queue's head.
  - outX_data is the head entry whenever outX_valid = 1.
  - outX_data holds its last value when the queue is empty.
- Simultaneous push and pop on the same non-full queue: occupancy is unchanged and both pointers advance.
- Pointers wrap modulo DEPTH.
- Occupancy is held in log2(DEPTH)+1 bits. Full when occupancy == DEPTH; empty when occupancy == 0.
- outX_valid and outX_data are stable while outX_ready = 0. They change only on a pop or on a push into an empty queue.
- Inputs are ignored when in_valid = 0; in_sel and in_data are don't-care.
- Counters wrap from 2^CNT_W-1 to 0 without any flag.

Test Plan:
- Reset held low for 2 cycles with in_valid = 1 → in both cycles and the cycle after release: outA_valid = outB_valid = 0, cntA = cntB = 0, and no words land in either queue.
- Push 0xA0000001 (sel 0), then 0xB0000002 (sel 1), outA_ready = outB_ready = 1 → each appears on its port one cycle after acceptance, and cntA = cntB = 1.
- outA_ready = 0, push 0x11, 0x22, 0x33 all with sel 0 → first two accepted. in_ready = 0 for 0x33 while held. After outA_ready = 1, outA_data reads 0x11, 0x22, 0x33 in order.
- Queue A full and stalled, offer words with sel 1 → in_ready = 1 and B drains normally. A is untouched: outA_data = 0x11 held throughout.
- Queue A at occupancy 1 with push and pop in the same cycle over 10 cycles (data 0..9) → outA_valid stays 1, order is preserved, and cntA = 10.
- Reset asserted while both queues are full → next cycle both valids = 0 and both counters = 0. The first word after release is the only one delivered.
- Push 256 words to B → cntB wraps to 0 and all 256 words are delivered in order.
